cond_unit: RTL and testbench
============================

# cond_unit

Execute-stage condition unit for the pipelined ARM datapath, directly downstream of the 32-bit ALU. It holds the architectural NZCV flag register, evaluates the 4-bit condition field of the instruction in Execute against the flags, gates the branch and write controls accordingly, and updates the flags from the ALU's `ALUFlags` output. Gated write controls are registered into the Execute→Memory pipeline register, with stall and flush support.

## Interface
- No parameters; all widths are fixed by the ISA.
- `clk` in 1: single clock, rising-edge.
- `reset` in 1: synchronous, active-high.
- `Cond` in 4: condition field (instr[31:28]) of the Execute instruction.
- `ALUFlags` in 4: `{V, C, N, Z}` from the ALU for the current Execute instruction.
- `FlagW` in 2: bit1 enables the N,Z update; bit0 enables the C,V update.
- `PCS` in 1: decoded branch or PC-write intent, before condition.
- `RegW` in 1: decoded register write, before condition.
- `MemW` in 1: decoded memory write, before condition.
- `NoWrite` in 1: suppresses the register write (CMP/CMN/TST/TEQ).
- `ValidE` in 1: Execute holds a real instruction.
- `StallE` in 1: Execute is held this cycle.
- `FlushM` in 1: load a bubble into the E→M register.
- `CondExE` out 1: condition passed, combinational.
- `PCSrcE` out 1: branch taken now, combinational, for the fetch redirect.
- `Flags` out 4: current registered `{V, C, N, Z}`.
- `PCSrcM` out 1: registered gated PCS.
- `RegWriteM` out 1: registered gated register write.
- `MemWriteM` out 1: registered gated memory write.

## Operation
- **Condition evaluation** (N, Z, C, V taken from the registered `Flags`):
  - 0 EQ: Z
  - 1 NE: ~Z
  - 2 CS: C
  - 3 CC: ~C
  - 4 MI: N
  - 5 PL: ~N
  - 6 VS: V
  - 7 VC: ~V
  - 8 HI: C&~Z
  - 9 LS: ~C|Z
  - A GE: N==V
  - B LT: N!=V
  - C GT: ~Z&(N==V)
  - D LE: Z|(N!=V)
  - E AL: 1
  - F: 0. Treated as never; no writes and no branch.
- **CondExE** = `ValidE & ~StallE & condpass`.
- **Gated controls:**
  - `PCSrcE = PCS & CondExE`
  - RegWrite gated = `RegW & ~NoWrite & CondExE`
  - MemWrite gated = `MemW & CondExE`
- **Flag update at the clock edge:**
  - If `CondExE & FlagW[1]`: load `Flags[1:0] <= ALUFlags[1:0]` (N,Z).
  - If `CondExE & FlagW[0]`: load `Flags[3:2] <= ALUFlags[3:2]` (V,C).
  - Each half updates independently. A failed condition leaves the flags untouched.
- **E→M register load priority:** reset > `FlushM` > `StallE` > normal.
  - Reset: all three outputs 0.
  - FlushM: all three outputs 0.
  - StallE: bubble (all 0). The held instruction re-enters on a later cycle, so nothing is issued twice.
  - Normal: gated `PCSrcE`, RegWrite, MemWrite.
- `FlushM` does not block the flag update for the instruction currently in E. The hazard unit flushes E separately by deasserting `ValidE`.

## Timing
- **Reset values:**
  - `Flags` = 4'b0000.
  - `PCSrcM`, `RegWriteM`, `MemWriteM` = 0.
  - `CondExE`/`PCSrcE` follow their inputs combinationally, so they are 0 whenever `ValidE` = 0.
- **Latency:**
  - `CondExE` and `PCSrcE`: 0 cycles.
  - `*M` outputs and the `Flags` update: 1 cycle.
- **Back-to-back flag use:** instruction i sets the flags at edge t. Instruction i+1, in E during cycle t+1, evaluates its condition against the new flags. No bypass is needed.
- **Same-instruction rule:** an instruction that both sets flags and is conditional evaluates its condition against the old flags.
- **Stall:** `Flags` hold and `*M` receive a bubble, for as long as `StallE` stays high.
- **Reset mid-operation:** reset takes effect at the next edge regardless of `StallE`, `FlushM` or `FlagW`.

## Structure
- **Package `arm_pkg`:**
  - `cond_t` enum for the 16 condition codes.
  - Flag index localparams: `FLAG_Z=0`, `FLAG_N=1`, `FLAG_C=2`, `FLAG_V=3`. These match the ALU's `ALUFlags` ordering.
  - `FLAGW_NZ=1`, `FLAGW_CV=0`.
- **Sub-module `cond_check`:** purely combinational, (`Cond`, `Flags`) → `condpass`. It is reused by a future single-cycle/multicycle control path.
- **`cond_unit` itself:** flag register, gating logic, and the E→M register.

## Test plan
1. **Reset:** assert `reset` for 2 cycles with `FlagW`=11, `ALUFlags`=4'b1111, `ValidE`=1 → `Flags`=0000 and all `*M`=0 after release.
2. **SUBS then BEQ:**
   - Cycle 1: `Cond`=E, `FlagW`=11, `ALUFlags`=0001 → `Flags`=0001.
   - Cycle 2: `Cond`=0, `PCS`=1 → `PCSrcE`=1, `PCSrcM`=1 the next cycle.
   - Repeat with `ALUFlags`=0000 → `PCSrcE`=0.
3. **Split update:**
   - `Flags`=1100, then `FlagW`=10 with `ALUFlags`=0011 → `Flags`=1111.
   - Then `FlagW`=01 with `ALUFlags`=0000 → `Flags`=0011.
4. **Condition sweep:** for all 16 `Cond` values × all 16 flag states, check `CondExE` against the Operation list. `Cond`=F always gives 0.
5. **Compare suppresses writes:** `RegW`=1, `NoWrite`=1, `Cond`=E, `FlagW`=11 → `RegWriteM`=0 and flags updated. With `Cond`=1 and Z=1 → flags unchanged, `MemWriteM`=0.
6. **Stall and flush:**
   - `StallE`=1 with `RegW`=1, `FlagW`=11 → `RegWriteM`=0 and `Flags` unchanged.
   - `FlushM`=1 with `StallE`=0, `MemW`=1 → `MemWriteM`=0 while the flags still update.

Source files
------------

// File: rtl/arm_pkg.sv
// Shared definitions for the ARM datapath control slice.
// Holds the condition-code enumeration, the bit positions of the NZCV
// flags as they appear on ALUFlags/Flags ({V, C, N, Z}), and the bit
// positions inside the two-bit FlagW control.
package arm_pkg;

  // The sixteen values of the instruction's condition field (instr[31:28]).
  typedef enum logic [3:0] {
    COND_EQ = 4'h0,
    COND_NE = 4'h1,
    COND_CS = 4'h2,
    COND_CC = 4'h3,
    COND_MI = 4'h4,
    COND_PL = 4'h5,
    COND_VS = 4'h6,
    COND_VC = 4'h7,
    COND_HI = 4'h8,
    COND_LS = 4'h9,
    COND_GE = 4'hA,
    COND_LT = 4'hB,
    COND_GT = 4'hC,
    COND_LE = 4'hD,
    COND_AL = 4'hE,
    COND_NV = 4'hF
  } cond_t;

  // Flag bit positions, matching the ALU's ALUFlags ordering.
  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;

  // FlagW bit positions: bit1 updates N,Z and bit0 updates C,V.
  localparam int FLAGW_NZ = 1;
  localparam int FLAGW_CV = 0;

endpackage

// File: rtl/cond_check.sv
// Combinational condition checker.
// Decides whether an instruction's condition field passes against a set
// of NZCV flags. Kept free of state so the single-cycle and multicycle
// control paths can share it.
// Ports:
//   Cond     in  4 : condition field of the instruction
//   Flags    in  4 : {V, C, N, Z}
//   condpass out 1 : high when the condition holds
import arm_pkg::*;

module cond_check (
  input  logic [3:0] Cond,
  input  logic [3:0] Flags,
  output logic       condpass
);

  logic flag_n;
  logic flag_z;
  logic flag_c;
  logic flag_v;

  assign flag_n = Flags[FLAG_N];
  assign flag_z = Flags[FLAG_Z];
  assign flag_c = Flags[FLAG_C];
  assign flag_v = Flags[FLAG_V];

  // Decode the condition field against the flags. The 0xF encoding is
  // treated as "never" so that it can not branch or write anything.
  always_comb begin
    condpass = 1'b0;
    case (cond_t'(Cond))
      COND_EQ: condpass = flag_z;
      COND_NE: condpass = ~flag_z;
      COND_CS: condpass = flag_c;
      COND_CC: condpass = ~flag_c;
      COND_MI: condpass = flag_n;
      COND_PL: condpass = ~flag_n;
      COND_VS: condpass = flag_v;
      COND_VC: condpass = ~flag_v;
      COND_HI: condpass = flag_c & ~flag_z;
      COND_LS: condpass = ~flag_c | flag_z;
      COND_GE: condpass = (flag_n == flag_v);
      COND_LT: condpass = (flag_n != flag_v);
      COND_GT: condpass = ~flag_z & (flag_n == flag_v);
      COND_LE: condpass = flag_z | (flag_n != flag_v);
      COND_AL: condpass = 1'b1;
      default: condpass = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_unit.sv
// Execute-stage condition unit.
// Holds the architectural NZCV register, evaluates the Execute
// instruction's condition against it, gates branch/register/memory write
// intents, updates the flags from the ALU, and registers the gated write
// controls into the Execute->Memory pipeline register.
// Ports:
//   clk, reset                : rising-edge clock, synchronous active-high reset
//   Cond, ALUFlags, FlagW     : condition field, ALU flags {V,C,N,Z}, flag write enables
//   PCS, RegW, MemW, NoWrite  : ungated control intents from decode
//   ValidE, StallE, FlushM    : pipeline validity, stall and flush controls
//   CondExE, PCSrcE           : combinational condition pass and branch-taken
//   Flags                     : registered {V,C,N,Z}
//   PCSrcM, RegWriteM, MemWriteM : registered gated controls for Memory
import arm_pkg::*;

module cond_unit (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic       PCS,
  input  logic       RegW,
  input  logic       MemW,
  input  logic       NoWrite,
  input  logic       ValidE,
  input  logic       StallE,
  input  logic       FlushM,
  output logic       CondExE,
  output logic       PCSrcE,
  output logic [3:0] Flags,
  output logic       PCSrcM,
  output logic       RegWriteM,
  output logic       MemWriteM
);

  logic [3:0] flags_q;
  logic [3:0] flags_d;
  logic       pcsrc_m_q;
  logic       pcsrc_m_d;
  logic       reg_write_m_q;
  logic       reg_write_m_d;
  logic       mem_write_m_q;
  logic       mem_write_m_d;
  logic       condpass;
  logic       reg_write_e;
  logic       mem_write_e;

  // The condition is always judged against the registered flags, so an
  // instruction that both sets flags and is conditional sees the old ones.
  cond_check u_cond_check (
    .Cond     (Cond),
    .Flags    (flags_q),
    .condpass (condpass)
  );

  // Gate the decoded intents. A stalled instruction is not considered
  // executed this cycle; it will be evaluated again when it is released.
  always_comb begin
    CondExE     = ValidE & ~StallE & condpass;
    PCSrcE      = PCS & CondExE;
    reg_write_e = RegW & ~NoWrite & CondExE;
    mem_write_e = MemW & CondExE;
  end

  // Next flags: the N,Z and C,V halves load independently. FlushM is
  // deliberately not considered here; squashing E is done via ValidE.
  always_comb begin
    flags_d = flags_q;
    if (CondExE && FlagW[FLAGW_NZ]) begin
      flags_d[FLAG_N] = ALUFlags[FLAG_N];
      flags_d[FLAG_Z] = ALUFlags[FLAG_Z];
    end
    if (CondExE && FlagW[FLAGW_CV]) begin
      flags_d[FLAG_C] = ALUFlags[FLAG_C];
      flags_d[FLAG_V] = ALUFlags[FLAG_V];
    end
  end

  // Next E->M contents: flush beats stall beats a normal load. Both flush
  // and stall insert a bubble.
  always_comb begin
    pcsrc_m_d     = PCSrcE;
    reg_write_m_d = reg_write_e;
    mem_write_m_d = mem_write_e;
    if (FlushM || StallE) begin
      pcsrc_m_d     = 1'b0;
      reg_write_m_d = 1'b0;
      mem_write_m_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q       <= 4'b0000;
      pcsrc_m_q     <= 1'b0;
      reg_write_m_q <= 1'b0;
      mem_write_m_q <= 1'b0;
    end else begin
      flags_q       <= flags_d;
      pcsrc_m_q     <= pcsrc_m_d;
      reg_write_m_q <= reg_write_m_d;
      mem_write_m_q <= mem_write_m_d;
    end
  end

  assign Flags     = flags_q;
  assign PCSrcM    = pcsrc_m_q;
  assign RegWriteM = reg_write_m_q;
  assign MemWriteM = mem_write_m_q;

endmodule

// File: tb/tb_cond_unit.sv
// Self-checking bench for cond_unit: directed scenarios followed by a
// randomized run, all compared against a behavioural model of the flags
// and the Memory-stage controls.
module tb_cond_unit;

  logic       clk;
  logic       reset;
  logic [3:0] Cond;
  logic [3:0] ALUFlags;
  logic [1:0] FlagW;
  logic       PCS;
  logic       RegW;
  logic       MemW;
  logic       NoWrite;
  logic       ValidE;
  logic       StallE;
  logic       FlushM;
  logic       CondExE;
  logic       PCSrcE;
  logic [3:0] Flags;
  logic       PCSrcM;
  logic       RegWriteM;
  logic       MemWriteM;

  int checkCount = 0;
  int passCount  = 0;

  // Model state: individual flag bits and the three Memory-stage controls.
  logic mN, mZ, mC, mV;
  logic mPcsrc, mRegW, mMemW;

  cond_unit dut (
    .clk       (clk),
    .reset     (reset),
    .Cond      (Cond),
    .ALUFlags  (ALUFlags),
    .FlagW     (FlagW),
    .PCS       (PCS),
    .RegW      (RegW),
    .MemW      (MemW),
    .NoWrite   (NoWrite),
    .ValidE    (ValidE),
    .StallE    (StallE),
    .FlushM    (FlushM),
    .CondExE   (CondExE),
    .PCSrcE    (PCSrcE),
    .Flags     (Flags),
    .PCSrcM    (PCSrcM),
    .RegWriteM (RegWriteM),
    .MemWriteM (MemWriteM)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the bench can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached, observed no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic [3:0] observed, input logic [3:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got %b, expected %b at %0t", tag, observed, expected, $time);
  endtask

  // Reference condition evaluation written from the ARM condition table.
  function automatic logic refPass(input int cond, input logic n, input logic z, input logic c, input logic v);
    logic ge;
    ge = (n == v);
    case (cond)
      0:  return z;
      1:  return !z;
      2:  return c;
      3:  return !c;
      4:  return n;
      5:  return !n;
      6:  return v;
      7:  return !v;
      8:  return c && !z;
      9:  return !c || z;
      10: return ge;
      11: return !ge;
      12: return !z && ge;
      13: return z || !ge;
      14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Drive one cycle of inputs, check combinational outputs against the
  // model, advance the model across the edge and check registered outputs.
  task automatic applyStimulus(input logic rst, input logic [3:0] cnd, input logic [3:0] alu,
                               input logic [1:0] fw, input logic pcs, input logic rw, input logic mw,
                               input logic nw, input logic vld, input logic stl, input logic fl);
    logic exec;
    logic takeBranch;
    @(negedge clk);
    reset = rst; Cond = cnd; ALUFlags = alu; FlagW = fw; PCS = pcs;
    RegW = rw; MemW = mw; NoWrite = nw; ValidE = vld; StallE = stl; FlushM = fl;
    #1;
    exec       = vld && !stl && refPass(int'(cnd), mN, mZ, mC, mV);
    takeBranch = pcs && exec;
    checkOutput("CondExE", {3'b000, CondExE}, {3'b000, exec});
    checkOutput("PCSrcE", {3'b000, PCSrcE}, {3'b000, takeBranch});
    @(posedge clk);
    if (rst) begin
      {mN, mZ, mC, mV} = 4'b0000;
      mPcsrc = 1'b0; mRegW = 1'b0; mMemW = 1'b0;
    end else begin
      if (exec && fw[1]) begin mN = alu[1]; mZ = alu[0]; end
      if (exec && fw[0]) begin mV = alu[3]; mC = alu[2]; end
      if (fl || stl) begin
        mPcsrc = 1'b0; mRegW = 1'b0; mMemW = 1'b0;
      end else begin
        mPcsrc = takeBranch;
        mRegW  = rw && !nw && exec;
        mMemW  = mw && exec;
      end
    end
    #1;
    checkOutput("Flags", Flags, {mV, mC, mN, mZ});
    checkOutput("PCSrcM", {3'b000, PCSrcM}, {3'b000, mPcsrc});
    checkOutput("RegWriteM", {3'b000, RegWriteM}, {3'b000, mRegW});
    checkOutput("MemWriteM", {3'b000, MemWriteM}, {3'b000, mMemW});
  endtask

  initial begin
    reset = 1'b1; Cond = 4'hE; ALUFlags = 4'hF; FlagW = 2'b11; PCS = 1'b0;
    RegW = 1'b0; MemW = 1'b0; NoWrite = 1'b0; ValidE = 1'b1; StallE = 1'b0; FlushM = 1'b0;
    {mN, mZ, mC, mV} = 4'b0000;
    mPcsrc = 1'b0; mRegW = 1'b0; mMemW = 1'b0;

    // Reset held two cycles while trying to set flags.
    applyStimulus(1, 4'hE, 4'hF, 2'b11, 0, 1, 1, 0, 1, 0, 0);
    applyStimulus(1, 4'hE, 4'hF, 2'b11, 0, 1, 1, 0, 1, 0, 0);
    checkOutput("reset Flags", Flags, 4'b0000);
    checkOutput("reset RegWriteM", {3'b000, RegWriteM}, 4'b0000);

    // SUBS setting Z then BEQ taken.
    applyStimulus(0, 4'hE, 4'b0001, 2'b11, 0, 1, 0, 0, 1, 0, 0);
    checkOutput("subs Flags", Flags, 4'b0001);
    applyStimulus(0, 4'h0, 4'b0000, 2'b00, 1, 0, 0, 0, 1, 0, 0);
    checkOutput("beq PCSrcM", {3'b000, PCSrcM}, 4'b0001);
    // Same again with Z clear: branch not taken.
    applyStimulus(0, 4'hE, 4'b0000, 2'b11, 0, 1, 0, 0, 1, 0, 0);
    applyStimulus(0, 4'h0, 4'b0000, 2'b00, 1, 0, 0, 0, 1, 0, 0);
    checkOutput("bne PCSrcM", {3'b000, PCSrcM}, 4'b0000);

    // Split update of the two flag halves.
    applyStimulus(0, 4'hE, 4'b1100, 2'b11, 0, 0, 0, 0, 1, 0, 0);
    applyStimulus(0, 4'hE, 4'b0011, 2'b10, 0, 0, 0, 0, 1, 0, 0);
    checkOutput("split NZ", Flags, 4'b1111);
    applyStimulus(0, 4'hE, 4'b0000, 2'b01, 0, 0, 0, 0, 1, 0, 0);
    checkOutput("split CV", Flags, 4'b0011);

    // Condition sweep over every flag state and condition code.
    for (int f = 0; f < 16; f++) begin
      applyStimulus(0, 4'hE, 4'(f), 2'b11, 0, 0, 0, 0, 1, 0, 0);
      for (int c = 0; c < 16; c++)
        applyStimulus(0, 4'(c), 4'(15 - f), 2'b00, 1, 1, 1, 0, 1, 0, 0);
    end

    // Compare instruction: writes flags, no register write.
    applyStimulus(0, 4'hE, 4'b0101, 2'b11, 0, 1, 0, 1, 1, 0, 0);
    checkOutput("cmp RegWriteM", {3'b000, RegWriteM}, 4'b0000);
    checkOutput("cmp Flags", Flags, 4'b0101);
    // NE with Z=1 fails: flags and memory write suppressed.
    applyStimulus(0, 4'h1, 4'b1010, 2'b11, 0, 0, 1, 0, 1, 0, 0);
    checkOutput("ne Flags", Flags, 4'b0101);
    checkOutput("ne MemWriteM", {3'b000, MemWriteM}, 4'b0000);

    // Stall: bubble and flags hold.
    applyStimulus(0, 4'hE, 4'b1010, 2'b11, 0, 1, 0, 0, 1, 1, 0);
    checkOutput("stall RegWriteM", {3'b000, RegWriteM}, 4'b0000);
    checkOutput("stall Flags", Flags, 4'b0101);
    // Flush: bubble but flags still update.
    applyStimulus(0, 4'hE, 4'b1010, 2'b11, 0, 0, 1, 0, 1, 0, 1);
    checkOutput("flush MemWriteM", {3'b000, MemWriteM}, 4'b0000);
    checkOutput("flush Flags", Flags, 4'b1010);

    // Randomized run.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(39) == 0), 4'($urandom_range(15)), 4'($urandom_range(15)),
                    2'($urandom_range(3)), 1'($urandom_range(1)), 1'($urandom_range(1)),
                    1'($urandom_range(1)), ($urandom_range(3) == 0), ($urandom_range(4) != 0),
                    ($urandom_range(4) == 0), ($urandom_range(6) == 0));
    end

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
